// File: rtl/ptp_extts_mc.sv
// Multi-channel external timestamp capture. Each channel has a trigger synchroniser, an edge detector
// and a holding register. One shared calibration subtractor feeds a first-word-fall-through event FIFO.
module ptp_extts_mc #(
  parameter int unsigned  CH_COUNT     = 4,
  parameter int unsigned  FIFO_DEPTH   = 16,
  parameter int unsigned  SYNC_STAGES  = 3,
  parameter bit           FNS_ENABLE   = 1'b1,
  parameter logic [95:0]  CALI_DEFAULT = 96'h0000_0000_0000_0000_0014_0000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [CH_COUNT-1:0]           trig_in,
  input  logic [95:0]                   input_ts_96,
  input  logic                          input_ts_step,
  input  logic [CH_COUNT-1:0]           ch_enable,
  input  logic [CH_COUNT-1:0]           edge_rise_en,
  input  logic [CH_COUNT-1:0]           edge_fall_en,
  input  logic [95:0]                   input_cali,
  input  logic                          input_cali_valid,
  input  logic                          step_clear,
  output logic [95:0]                   m_ts,
  output logic [3:0]                    m_channel,
  output logic                          m_edge,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [15:0]                   overflow_count,
  output logic                          step
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [CH_COUNT-1:0] sync_q [SYNC_STAGES];
  logic [CH_COUNT-1:0] dly_q, pending_q, pending_d;
  logic [95:0]         hold_ts_q [CH_COUNT];
  logic [CH_COUNT-1:0] hold_edge_q;
  logic                gnt_vld_q, cal_vld_q, gnt_edge_q, cal_edge_q;
  logic [95:0]         gnt_ts_q, cal_ts_q, cali_q, corr_ts;
  logic [3:0]          gnt_ch_q, cal_ch_q;
  logic [100:0]        mem_q [FIFO_DEPTH];
  logic [AW-1:0]       wptr_q, rptr_q;
  logic [CW-1:0]       count_q;
  logic [15:0]         ovf_q, ovf_d;
  logic                step_q, step_d;

  logic [CH_COUNT-1:0] sync_out, rise, evt, accept, drop_hold;
  logic                g_found, g_edge, rd, wr, drop_fifo, b0, b1;
  logic [CH_COUNT-1:0] g_oh;
  logic [95:0]         g_ts;
  logic [3:0]          g_ch;
  logic [5:0]          drops;
  logic [16:0]         fns_diff, ovf_sum;
  logic [31:0]         ns_diff;
  logic [15:0]         fns_res;
  logic [29:0]         ns_res;
  logic [47:0]         s_res;

  always_comb begin
    sync_out  = sync_q[SYNC_STAGES-1];
    rise      = sync_out & ~dly_q;
    evt       = ch_enable & ((rise & edge_rise_en) | (~sync_out & dly_q & edge_fall_en));
    accept    = input_ts_step ? '0 : (evt & ~pending_q);
    drop_hold = input_ts_step ? '0 : (evt & pending_q);
    g_found   = 1'b0;
    g_oh      = '0;
    g_ts      = '0;
    g_ch      = '0;
    g_edge    = 1'b0;
    for (int unsigned i = 0; i < CH_COUNT; i++) begin
      if (pending_q[i] && !g_found) begin
        g_found = 1'b1;
        g_oh[i] = 1'b1;
        g_ts    = hold_ts_q[i];
        g_ch    = 4'(i);
        g_edge  = hold_edge_q[i];
      end
    end
    pending_d = input_ts_step ? '0 : ((pending_q & ~g_oh) | accept);
  end

  // Calibration subtract with fns->ns and ns->s borrows.
  always_comb begin
    fns_diff = {1'b0, gnt_ts_q[15:0]} - {1'b0, cali_q[15:0]};
    b0       = FNS_ENABLE ? fns_diff[16] : 1'b0;
    fns_res  = FNS_ENABLE ? fns_diff[15:0] : 16'd0;
    ns_diff  = {2'b00, gnt_ts_q[45:16]} - {2'b00, cali_q[45:16]} - {31'd0, b0};
    b1       = ns_diff[31];
    ns_res   = 30'(b1 ? (ns_diff + 32'd1_000_000_000) : ns_diff);
    s_res    = gnt_ts_q[95:48] - cali_q[95:48] - {47'd0, b1};
    corr_ts  = {s_res, 2'b00, ns_res, fns_res};
  end

  always_comb begin
    rd        = (count_q != '0) && m_ready;
    wr        = cal_vld_q && ((count_q != CW'(FIFO_DEPTH)) || rd) && !input_ts_step;
    drop_fifo = cal_vld_q && (count_q == CW'(FIFO_DEPTH)) && !rd && !input_ts_step;
    drops     = {5'd0, drop_fifo};
    for (int unsigned i = 0; i < CH_COUNT; i++) drops = drops + {5'd0, drop_hold[i]};
    ovf_sum   = {1'b0, ovf_q} + {11'd0, drops};
    ovf_d     = ovf_sum[16] ? 16'hFFFF : ovf_sum[15:0];
    step_d    = input_ts_step ? 1'b1 : (step_clear ? 1'b0 : step_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      for (int unsigned i = 0; i < CH_COUNT; i++) hold_ts_q[i] <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      dly_q       <= '0;
      pending_q   <= '0;
      hold_edge_q <= '0;
      gnt_vld_q   <= 1'b0;
      gnt_ts_q    <= '0;
      gnt_ch_q    <= '0;
      gnt_edge_q  <= 1'b0;
      cal_vld_q   <= 1'b0;
      cal_ts_q    <= '0;
      cal_ch_q    <= '0;
      cal_edge_q  <= 1'b0;
      cali_q      <= CALI_DEFAULT;
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      ovf_q       <= '0;
      step_q      <= 1'b0;
    end else begin
      sync_q[0] <= trig_in;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      dly_q     <= sync_out;
      pending_q <= pending_d;
      ovf_q     <= ovf_d;
      step_q    <= step_d;
      if (input_cali_valid) cali_q <= input_cali;
      for (int unsigned i = 0; i < CH_COUNT; i++) begin
        if (accept[i]) begin
          hold_ts_q[i]   <= input_ts_96;
          hold_edge_q[i] <= rise[i];
        end
      end
      gnt_vld_q  <= g_found && !input_ts_step;
      gnt_ts_q   <= g_ts;
      gnt_ch_q   <= g_ch;
      gnt_edge_q <= g_edge;
      cal_vld_q  <= gnt_vld_q && !input_ts_step;
      cal_ts_q   <= corr_ts;
      cal_ch_q   <= gnt_ch_q;
      cal_edge_q <= gnt_edge_q;
      if (input_ts_step) begin
        wptr_q  <= '0;
        rptr_q  <= '0;
        count_q <= '0;
      end else begin
        if (wr) begin
          mem_q[wptr_q] <= {cal_ts_q, cal_ch_q, cal_edge_q};
          wptr_q        <= wptr_q + 1'b1;
        end
        if (rd) rptr_q <= rptr_q + 1'b1;
        count_q <= count_q + CW'(wr) - CW'(rd);
      end
    end
  end

  assign m_ts           = mem_q[rptr_q][100:5];
  assign m_channel      = mem_q[rptr_q][4:1];
  assign m_edge         = mem_q[rptr_q][0];
  assign m_valid        = (count_q != '0);
  assign fifo_count     = count_q;
  assign overflow_count = ovf_q;
  assign step           = step_q;
endmodule
